alu_driver: RTL and testbench

Sequential command front-end for the 4-bit combinational ALU: it sits on the requester side of the ALU's S/A/B/result interface. It accepts operation commands over a valid/ready handshake, buffers them in a small FIFO, drives registered opcode/operands into the ALU and captures the 5-bit result. It returns each result with flags over a second valid/ready handshake, and keeps an accumulator so operations can be chained.

---
 rtl/alu_driver_if.sv | 25 ++
 rtl/alu_driver.sv | 135 +++++++++++++
 tb/tb_alu_driver.sv | 273 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/alu_driver_if.sv
// Command and response handshake bundle between a requester and alu_driver.
`timescale 1ns/1ps
interface alu_driver_if;
  logic       cmd_valid;
  logic       cmd_ready;
  logic [3:0] cmd_op;
  logic [3:0] cmd_a;
  logic [3:0] cmd_b;
  logic       cmd_use_acc;
  logic       rsp_valid;
  logic       rsp_ready;
  logic [4:0] rsp_result;
  logic       rsp_zero;
  logic       rsp_carry;

  modport master (
    output cmd_valid, cmd_op, cmd_a, cmd_b, cmd_use_acc, rsp_ready,
    input  cmd_ready, rsp_valid, rsp_result, rsp_zero, rsp_carry
  );

  modport slave (
    input  cmd_valid, cmd_op, cmd_a, cmd_b, cmd_use_acc, rsp_ready,
    output cmd_ready, rsp_valid, rsp_result, rsp_zero, rsp_carry
  );
endinterface

// File: rtl/alu_driver.sv
// Sequential command front-end for a 4-bit combinational ALU: command FIFO,
// registered operand issue, result capture with accumulator chaining.
`timescale 1ns/1ps
module alu_driver #(
  parameter int unsigned CMD_DEPTH = 4
) (
  input  logic         clk,
  input  logic         rst_n,
  alu_driver_if.slave  bus,
  input  logic         acc_clr,
  output logic [3:0]   alu_s,
  output logic [3:0]   alu_a,
  output logic [3:0]   alu_b,
  input  logic [4:0]   alu_result,
  output logic [4:0]   acc,
  output logic [7:0]   op_count,
  output logic         busy
);

  localparam int unsigned AW = (CMD_DEPTH > 1) ? $clog2(CMD_DEPTH) : 1;
  localparam logic [AW:0] FULL = CMD_DEPTH[AW:0];

  typedef struct packed {
    logic [3:0] op;
    logic [3:0] a;
    logic [3:0] b;
    logic       use_acc;
  } cmd_t;

  typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;

  state_t        state, state_next;
  cmd_t          mem [CMD_DEPTH];
  cmd_t          head;
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [AW:0]   count;
  logic [4:0]    rsp_result;
  logic          push, load, capture, rsp_done;
  logic          fifo_empty;

  assign fifo_empty    = (count == '0);
  assign head          = mem[rd_ptr];
  assign bus.cmd_ready = (count != FULL);
  assign push          = bus.cmd_valid && bus.cmd_ready;

  assign bus.rsp_valid  = (state == RESP);
  assign bus.rsp_result = rsp_result;
  assign bus.rsp_zero   = (rsp_result == '0);
  assign bus.rsp_carry  = rsp_result[4];
  assign busy           = (state != IDLE) || !fifo_empty;

  // Command FIFO; the pop coincides with the EXEC capture edge.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= '{op: bus.cmd_op, a: bus.cmd_a, b: bus.cmd_b,
                               use_acc: bus.cmd_use_acc};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push)    wr_ptr <= wr_ptr + 1'b1;
      if (capture) rd_ptr <= rd_ptr + 1'b1;
      case ({push, capture})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_next;
  end

  always_comb begin
    state_next = state;
    load       = 1'b0;
    capture    = 1'b0;
    rsp_done   = 1'b0;
    case (state)
      IDLE: begin
        if (!fifo_empty) begin
          load       = 1'b1;
          state_next = EXEC;
        end
      end
      EXEC: begin
        capture    = 1'b1;
        state_next = RESP;
      end
      RESP: begin
        if (bus.rsp_ready) begin
          rsp_done = 1'b1;
          // count already excludes the command popped at capture
          if (!fifo_empty) begin
            load       = 1'b1;
            state_next = EXEC;
          end else begin
            state_next = IDLE;
          end
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      alu_s      <= '0;
      alu_a      <= '0;
      alu_b      <= '0;
      rsp_result <= '0;
      acc        <= '0;
      op_count   <= '0;
    end else begin
      if (load) begin
        alu_s <= head.op;
        alu_a <= head.use_acc ? acc[3:0] : head.a;
        alu_b <= head.b;
      end
      if (capture) begin
        rsp_result <= alu_result;
        acc        <= alu_result;
      end else if (acc_clr) begin
        acc <= '0;
      end
      if (rsp_done) op_count <= op_count + 1'b1;
    end
  end

endmodule

// File: tb/tb_alu_driver.sv
// Scoreboard bench for alu_driver with a behavioural ALU on the result port.
`timescale 1ns/1ps
module tb_alu_driver;
  logic       clk = 1'b0;
  logic       rst_n;
  logic       acc_clr;
  logic [3:0] alu_s, alu_a, alu_b;
  logic [4:0] alu_result;
  logic [4:0] acc;
  logic [7:0] op_count;
  logic       busy;

  always #5 clk = ~clk;

  alu_driver_if ifc();

  alu_driver #(.CMD_DEPTH(4)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .bus        (ifc),
    .acc_clr    (acc_clr),
    .alu_s      (alu_s),
    .alu_a      (alu_a),
    .alu_b      (alu_b),
    .alu_result (alu_result),
    .acc        (acc),
    .op_count   (op_count),
    .busy       (busy)
  );

  function automatic logic [4:0] alu_f(input logic [3:0] op, input logic [3:0] a,
                                       input logic [3:0] b);
    case (op)
      4'd0:    return {1'b0, a} + {1'b0, b};
      4'd1:    return {1'b0, a} - {1'b0, b};
      4'd2:    return {1'b0, a & b};
      4'd3:    return {1'b0, a | b};
      4'd4:    return {1'b0, a ^ b};
      4'd7:    return {4'b0000, a == b};
      default: return {op[0], a ^ ~b};
    endcase
  endfunction

  always_comb alu_result = alu_f(alu_s, alu_a, alu_b);

  int         checks = 0;
  int         failures = 0;
  logic [4:0] exp_q[$];
  logic [4:0] model_acc = '0;
  int unsigned mon_cnt = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
    end
  endtask

  // Monitor: a response is consumed at the next rising edge when valid&&ready.
  always @(negedge clk) begin
    if (!rst_n) begin
      mon_cnt = 0;
    end else if (ifc.rsp_valid && ifc.rsp_ready) begin
      if (exp_q.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL rsp_unexpected actual=%0d expected=none", ifc.rsp_result);
      end else begin
        logic [4:0] e;
        e = exp_q.pop_front();
        check("rsp_result", 32'(ifc.rsp_result), 32'(e));
        check("rsp_zero", 32'(ifc.rsp_zero), 32'(e == 5'd0));
        check("rsp_carry", 32'(ifc.rsp_carry), 32'(e[4]));
        check("op_count_at_rsp", 32'(op_count), 32'(mon_cnt[7:0]));
      end
      mon_cnt++;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Reference: responses return in order, so acc at issue is the previous result.
  task automatic send(input logic [3:0] op, input logic [3:0] a, input logic [3:0] b,
                      input logic ua, output logic accepted);
    logic [4:0] r;
    ifc.cmd_valid   = 1'b1;
    ifc.cmd_op      = op;
    ifc.cmd_a       = a;
    ifc.cmd_b       = b;
    ifc.cmd_use_acc = ua;
    accepted = ifc.cmd_ready;
    if (accepted) begin
      r = alu_f(op, ua ? model_acc[3:0] : a, b);
      model_acc = r;
      exp_q.push_back(r);
    end
    tick();
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    exp_q.delete();
    model_acc = '0;
    repeat (3) tick();
    rst_n = 1'b1;
    tick();
  endtask

  task automatic drain(input string name);
    int n;
    n = 0;
    while ((exp_q.size() != 0 || busy) && n < 200) begin
      tick();
      n++;
    end
    check({name, "_queue_empty"}, 32'(exp_q.size()), 32'd0);
    check({name, "_idle"}, 32'(busy), 32'd0);
  endtask

  task automatic check_reset_values(input string tag);
    check({tag, "_cmd_ready"}, 32'(ifc.cmd_ready), 32'd1);
    check({tag, "_rsp_valid"}, 32'(ifc.rsp_valid), 32'd0);
    check({tag, "_busy"}, 32'(busy), 32'd0);
    check({tag, "_alu_sab"}, {20'd0, alu_s, alu_a, alu_b}, 32'd0);
    check({tag, "_rsp_result"}, 32'(ifc.rsp_result), 32'd0);
    check({tag, "_rsp_zero"}, 32'(ifc.rsp_zero), 32'd1);
    check({tag, "_rsp_carry"}, 32'(ifc.rsp_carry), 32'd0);
    check({tag, "_acc"}, 32'(acc), 32'd0);
    check({tag, "_op_count"}, 32'(op_count), 32'd0);
  endtask

  initial begin
    logic ok;
    int   hs[$];
    int   idx;

    rst_n = 1'b0;
    acc_clr = 1'b0;
    ifc.cmd_valid = 1'b0;
    ifc.cmd_op = '0;
    ifc.cmd_a = '0;
    ifc.cmd_b = '0;
    ifc.cmd_use_acc = 1'b0;
    ifc.rsp_ready = 1'b0;
    repeat (2) tick();
    check_reset_values("reset");
    rst_n = 1'b1;
    tick();

    // Latency: push at E0, operands after E1, rsp_valid after E2, handshake at E3.
    ifc.rsp_ready = 1'b1;
    send(4'd0, 4'd9, 4'd8, 1'b0, ok);
    ifc.cmd_valid = 1'b0;
    check("lat_accepted", 32'(ok), 32'd1);
    check("lat_e0_rsp_valid", 32'(ifc.rsp_valid), 32'd0);
    tick();
    check("lat_e1_operands", {20'd0, alu_s, alu_a, alu_b}, {20'd0, 4'd0, 4'd9, 4'd8});
    check("lat_e1_rsp_valid", 32'(ifc.rsp_valid), 32'd0);
    tick();
    check("lat_e2_rsp_valid", 32'(ifc.rsp_valid), 32'd1);
    check("lat_e2_result", 32'(ifc.rsp_result), 32'd17);
    check("lat_e2_carry", 32'(ifc.rsp_carry), 32'd1);
    tick();
    check("lat_e3_rsp_valid", 32'(ifc.rsp_valid), 32'd0);
    check("lat_e3_op_count", 32'(op_count), 32'd1);
    drain("lat");

    // Chaining through acc[3:0]
    do_reset();
    ifc.rsp_ready = 1'b1;
    send(4'd0, 4'd3, 4'd4, 1'b0, ok);
    send(4'd0, 4'd15, 4'd2, 1'b1, ok);
    ifc.cmd_valid = 1'b0;
    drain("chain");
    check("chain_acc", 32'(acc), 32'd9);
    check("chain_op_count", 32'(op_count), 32'd2);

    // Backpressure: five fit (one already popped), the sixth is refused
    do_reset();
    ifc.rsp_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      send(4'($urandom_range(0, 7)), 4'($urandom), 4'($urandom), 1'($urandom), ok);
      check("bp_accepted", 32'(ok), 32'd1);
    end
    check("bp_full_ready", 32'(ifc.cmd_ready), 32'd0);
    send(4'd0, 4'd1, 4'd1, 1'b0, ok);
    ifc.cmd_valid = 1'b0;
    check("bp_sixth_refused", 32'(ok), 32'd0);
    repeat (3) tick();
    check("bp_stall_valid", 32'(ifc.rsp_valid), 32'd1);
    check("bp_stall_op_count", 32'(op_count), 32'd0);
    ifc.rsp_ready = 1'b1;
    idx = 0;
    while ((exp_q.size() != 0 || busy) && idx < 40) begin
      if (ifc.rsp_valid) hs.push_back(idx);
      tick();
      idx++;
    end
    check("bp_rsp_count", 32'(hs.size()), 32'd5);
    for (int i = 1; i < hs.size(); i++)
      check("bp_rsp_spacing", 32'(hs[i] - hs[i-1]), 32'd2);
    check("bp_op_count", 32'(op_count), 32'd5);
    drain("bp");

    // SUB, EQ, and acc_clr against the capture edge
    ifc.rsp_ready = 1'b1;
    send(4'd1, 4'd3, 4'd5, 1'b0, ok);
    ifc.cmd_valid = 1'b0;
    drain("sub");
    check("sub_acc", 32'(acc), 32'd30);
    send(4'd7, 4'd6, 4'd6, 1'b0, ok);
    ifc.cmd_valid = 1'b0;
    tick();
    acc_clr = 1'b1;
    tick();
    check("clr_on_capture_acc", 32'(acc), 32'd1);
    tick();
    acc_clr = 1'b0;
    model_acc = '0;
    check("clr_later_acc", 32'(acc), 32'd0);
    send(4'd0, 4'd15, 4'd5, 1'b1, ok);
    ifc.cmd_valid = 1'b0;
    drain("after_clr");
    check("after_clr_acc", 32'(acc), 32'd5);

    // Reset while holding a response with two commands queued
    ifc.rsp_ready = 1'b0;
    for (int i = 0; i < 3; i++) send(4'd0, 4'(i + 1), 4'd1, 1'b0, ok);
    ifc.cmd_valid = 1'b0;
    idx = 0;
    while (!ifc.rsp_valid && idx < 20) begin
      tick();
      idx++;
    end
    check("rst_mid_in_resp", 32'(ifc.rsp_valid), 32'd1);
    rst_n = 1'b0;
    exp_q.delete();
    model_acc = '0;
    #1;
    check_reset_values("rst_mid");
    repeat (2) tick();
    rst_n = 1'b1;
    ifc.rsp_ready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      tick();
      check("rst_mid_no_rsp", 32'(ifc.rsp_valid), 32'd0);
    end

    // Randomized traffic with random backpressure
    do_reset();
    for (int i = 0; i < 400; i++) begin
      ifc.rsp_ready = ($urandom_range(0, 3) != 0);
      if ($urandom_range(0, 1) == 1)
        send(4'($urandom), 4'($urandom), 4'($urandom), 1'($urandom), ok);
      else begin
        ifc.cmd_valid = 1'b0;
        tick();
      end
    end
    ifc.cmd_valid = 1'b0;
    ifc.rsp_ready = 1'b1;
    drain("rand");
    check("rand_op_count", 32'(op_count), 32'(mon_cnt[7:0]));
    check("rand_acc", 32'(acc), 32'(model_acc));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
